// File: rtl/traffic_light_controller.sv
// traffic_light_controller: main/side road intersection sequencer, 1 clock = 1 s.
// Main road rests on green; the side-road SENSOR requests a side-green phase
// bounded by minimum/maximum times. State, elapsed count and lamps are registered.
// Optional feature macro: ALL_RED_EN inserts an all-red clearance phase
// (ALL_RED_TIME cycles) after each yellow.
module traffic_light_controller #(
    parameter int MAIN_MIN_GREEN = 30,
    parameter int SIDE_MIN_GREEN = 5,
    parameter int SIDE_MAX_GREEN = 20,
    parameter int YELLOW_TIME    = 5,
    parameter int ALL_RED_TIME   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SENSOR,
    output logic [2:0] main_road,
    output logic [2:0] side_road,
    output logic [7:0] count
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
        SIDE_YELLOW = 3'd3,
        ALL_RED_1   = 3'd4,
        ALL_RED_2   = 3'd5
    } state_t;

    // Lamp encodings {red,yellow,green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Phase limits expressed as "last count value" so comparisons are on count directly
    localparam logic [7:0] MAIN_MIN_M1 = 8'(MAIN_MIN_GREEN - 1);
    localparam logic [7:0] SIDE_MIN_M1 = 8'(SIDE_MIN_GREEN - 1);
    localparam logic [7:0] SIDE_MAX_M1 = 8'(SIDE_MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_M1   = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALL_RED_M1  = 8'(ALL_RED_TIME - 1);

    // Where each yellow leads: straight to the opposite green, or through clearance
`ifdef ALL_RED_EN
    localparam state_t AFTER_MAIN_YELLOW = ALL_RED_1;
    localparam state_t AFTER_SIDE_YELLOW = ALL_RED_2;
`else
    localparam state_t AFTER_MAIN_YELLOW = SIDE_GREEN;
    localparam state_t AFTER_SIDE_YELLOW = MAIN_GREEN;
`endif

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic [7:0] fixed_last;
    logic       fixed_done;

    // Next state, elapsed count and lamps for the state being entered
    always_comb begin
        state_d    = state_q;
        fixed_last = ((state_q == ALL_RED_1) || (state_q == ALL_RED_2)) ? ALL_RED_M1 : YELLOW_M1;
        fixed_done = (count_q == fixed_last);

        case (state_q)
            MAIN_GREEN:  if (SENSOR && (count_q >= MAIN_MIN_M1)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (fixed_done) state_d = AFTER_MAIN_YELLOW;
            SIDE_GREEN:  if ((count_q == SIDE_MAX_M1) || (!SENSOR && (count_q >= SIDE_MIN_M1)))
                             state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (fixed_done) state_d = AFTER_SIDE_YELLOW;
`ifdef ALL_RED_EN
            ALL_RED_1:   if (fixed_done) state_d = SIDE_GREEN;
            ALL_RED_2:   if (fixed_done) state_d = MAIN_GREEN;
`endif
            default:     state_d = MAIN_GREEN;   // unreachable/illegal encoding recovers
        endcase

        // Count restarts on every state entry and saturates while a state is held
        if (state_d != state_q)
            count_d = 8'd0;
        else if (count_q == 8'hFF)
            count_d = count_q;
        else
            count_d = count_q + 8'd1;

        // Lamps decoded from the next state so they change on the same edge as the state
        main_d = LAMP_RED;
        side_d = LAMP_RED;
        case (state_d)
            MAIN_GREEN:  main_d = LAMP_GREEN;
            MAIN_YELLOW: main_d = LAMP_YELLOW;
            SIDE_GREEN:  side_d = LAMP_GREEN;
            SIDE_YELLOW: side_d = LAMP_YELLOW;
            default:     ;                       // all-red clearance
        endcase
    end

    // State, count and lamp registers with asynchronous reset to main green
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MAIN_GREEN;
            count_q <= 8'd0;
            main_q  <= LAMP_GREEN;
            side_q  <= LAMP_RED;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            main_q  <= main_d;
            side_q  <= side_d;
        end
    end

    assign main_road = main_q;
    assign side_road = side_q;
    assign count     = count_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: a phase-sequence model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// Honours ALL_RED_EN the same way the design does.
module tb_traffic_light_controller;

    localparam int MMIN = 30;
    localparam int SMIN = 5;
    localparam int SMAX = 20;
    localparam int YT   = 5;
    localparam int ART  = 2;
`ifdef ALL_RED_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif
    localparam int AR   = AR_EN ? ART : 0;     // clearance cycles added after each yellow
    localparam int NPH  = AR_EN ? 6 : 4;

    // Phase kinds used by the model
    localparam int K_MG = 0, K_MY = 1, K_SG = 2, K_SY = 3, K_AR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SENSOR = 1'b1;
    logic [2:0] main_road, side_road;
    logic [7:0] count;

    int checks = 0;
    int passed = 0;

    traffic_light_controller #(
        .MAIN_MIN_GREEN(MMIN), .SIDE_MIN_GREEN(SMIN), .SIDE_MAX_GREEN(SMAX),
        .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
    ) dut (
        .clk(clk), .rst(rst), .SENSOR(SENSOR),
        .main_road(main_road), .side_road(side_road), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int kind_of(input int idx);
        if (AR_EN) begin
            case (idx)
                0: return K_MG; 1: return K_MY; 2: return K_AR;
                3: return K_SG; 4: return K_SY; default: return K_AR;
            endcase
        end
        case (idx)
            0: return K_MG; 1: return K_MY; 2: return K_SG; default: return K_SY;
        endcase
    endfunction

    // Does a phase of this kind end at the edge where 'el' seconds have elapsed?
    function automatic bit phase_ends(input int k, input int el, input logic s);
        case (k)
            K_MG:       return s && (el >= MMIN - 1);
            K_MY, K_SY: return (el + 1) == YT;
            K_SG:       return ((el + 1) == SMAX) || (!s && (el + 1) >= SMIN);
            default:    return (el + 1) == ART;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(input int k);
        return (k == K_MG) ? 3'b001 : (k == K_MY) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] side_lamp(input int k);
        return (k == K_SG) ? 3'b001 : (k == K_SY) ? 3'b010 : 3'b100;
    endfunction

    int m_idx = 0;
    int m_el  = 0;

    // Model advances one second per rising edge; reset returns it to main green
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx <= 0;
            m_el  <= 0;
        end else if (phase_ends(kind_of(m_idx), m_el, SENSOR)) begin
            m_idx <= (m_idx + 1) % NPH;
            m_el  <= 0;
        end else begin
            m_el  <= m_el + 1;
        end
    end

    // Every falling edge: DUT outputs must match the model
    always @(negedge clk) begin
        chk("model main_road", {29'd0, main_road}, {29'd0, main_lamp(kind_of(m_idx))});
        chk("model side_road", {29'd0, side_road}, {29'd0, side_lamp(kind_of(m_idx))});
        chk("model count", {24'd0, count}, (m_el > 255) ? 32'd255 : 32'(m_el));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin(input string nm, input logic [2:0] m, input logic [2:0] s, input int c);
        chk({nm, " main"}, {29'd0, main_road}, {29'd0, m});
        chk({nm, " side"}, {29'd0, side_road}, {29'd0, s});
        chk({nm, " count"}, {24'd0, count}, 32'(c));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        pin("reset", 3'b001, 3'b100, 0);
        rst = 1'b0;
    endtask

    initial begin
        // Constant SENSOR=1: one full cycle of the intersection
        SENSOR = 1'b1;
        do_reset();
        tick(1);        pin("mg first count", 3'b001, 3'b100, 1);
        tick(29);       pin("main yellow entry", 3'b010, 3'b100, 0);
        tick(4);        pin("main yellow last", 3'b010, 3'b100, 4);
        tick(1 + AR);   pin("side green entry", 3'b100, 3'b001, 0);
        tick(20);       pin("side max -> yellow", 3'b100, 3'b010, 0);
        tick(5 + AR);   pin("period back to main", 3'b001, 3'b100, 0);
        tick(70);

        // SENSOR=0: main green forever, count saturates
        SENSOR = 1'b0;
        do_reset();
        tick(300);      pin("saturate", 3'b001, 3'b100, 255);

        // Late request at count 50
        do_reset();
        tick(50);       pin("mg count 50", 3'b001, 3'b100, 50);
        SENSOR = 1'b1;
        tick(1);        pin("late request", 3'b010, 3'b100, 0);
        tick(5 + AR);   pin("side green 2", 3'b100, 3'b001, 0);

        // Sensor drop early in side green: minimum green still served
        tick(2);        pin("sg count 2", 3'b100, 3'b001, 2);
        SENSOR = 1'b0;
        tick(2);        pin("sg min hold", 3'b100, 3'b001, 4);
        tick(1);        pin("sg min exit", 3'b100, 3'b010, 0);

        // Sensor drop after minimum: leaves on the next edge
        SENSOR = 1'b1;
        tick(40 + 2 * AR); pin("side green 3", 3'b100, 3'b001, 0);
        tick(10);       pin("sg count 10", 3'b100, 3'b001, 10);
        SENSOR = 1'b0;
        tick(1);        pin("sg drop exit", 3'b100, 3'b010, 0);

        // Asynchronous reset in the middle of side green
        SENSOR = 1'b1;
        tick(40 + 2 * AR); pin("side green 4", 3'b100, 3'b001, 0);
        tick(7);        pin("sg count 7", 3'b100, 3'b001, 7);
        #2 rst = 1'b1;
        #1 pin("async reset", 3'b001, 3'b100, 0);
        @(negedge clk);
        rst = 1'b0;
        SENSOR = 1'b0;
        tick(1);        pin("after reset release", 3'b001, 3'b100, 1);

        // A SENSOR pulse that misses every rising edge is ignored
        tick(39);       pin("mg count 40", 3'b001, 3'b100, 40);
        #1 SENSOR = 1'b1;
        #2 SENSOR = 1'b0;
        @(negedge clk); pin("glitch ignored", 3'b001, 3'b100, 41);
        tick(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
